c1_bus_sequencer: RTL and testbench
===================================

Name: c1_bus_sequencer

Overview:
- Sequences every 68K bus cycle decoded by the C1 address decoder.
- Latches the active zone when nAS falls and applies a per-zone wait-state count, including the cartridge-driven waits (nROMWAIT, nPWAIT1:0, PDTACK).
- Drives nDTACK and, optionally, a bus-error timeout.
- Sits between the C1 zone decode and the 68K core, replacing the fixed DTACK path.

Parameters:
- WAIT_CARD, 2, wait states for the memory-card zone.
- WAIT_PAL, 1, wait states for the palette zone.
- WAIT_SROM, 0, wait states for the system ROM zone.
- TIMEOUT_CYCLES, 255, clocks from nAS sample to nBERR assertion (8-bit counter; only used with the optional feature).

Ports:
- CLK_68KCLK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- nAS, RW, nLDS, nUDS  in  1 each  68K strobes; synchronous to CLK_68KCLK.
- nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE, nSRAM_ZONE, nPAL_ZONE  in  1 each  active-low zone selects.
- nROMWAIT  in  1  low = one extra ROM wait.
- nPWAIT1, nPWAIT0  in  1 each  port wait code.
- PDTACK  in  1  high = port device ready.
- nDTACK  out  1  registered, active-low.
- nBERR  out  1  registered, active-low; only driven low when the optional feature is compiled in.
- BUSY  out  1  high while a cycle is in progress.
- ZONE_ID  out  3  latched zone of the current or last cycle.

Behaviour:
- Reset state: nDTACK=1, nBERR=1, BUSY=0, ZONE_ID=ZN_NONE (7), state=IDLE, counters=0. Reset asserted mid-cycle aborts the cycle immediately; outputs return to reset values with no DTACK glitch.
- Zone encode: priority ROM(0) > WRAM(1) > PORT(2) > IO(3) > CARD(4) > SROM(5) > SRAM(6). If no select is low, the zone is NONE(7).
- Wait count W, decided at the capture edge:
  - ROM: 1 if nROMWAIT=0, else 0.
  - PORT: {nPWAIT1,nPWAIT0} 11→0, 10→1, 01→2, 00→3.
  - CARD: WAIT_CARD. SROM: WAIT_SROM. PAL: WAIT_PAL.
  - WRAM, IO, SRAM: 0.
  - PAL overrides the encoder result when nPAL_ZONE=0; PAL is reported as ZONE_ID 6 only if nSRAM_ZONE=1.
- States:
  - IDLE: on an edge with nAS=0 and a mapped zone, latch ZONE_ID, set BUSY=1, load cnt=W. This is capture edge 0. Next state is ACK if W=0, else WAIT. If the zone is NONE, go to HANG with BUSY=1.
  - WAIT: cnt decrements once per edge. At cnt=1, go to PREADY if the zone is PORT, else ACK.
  - PREADY: stay until PDTACK=1, then go to ACK.
  - ACK: nDTACK=0, held while nAS=0. On the first edge with nAS=1: nDTACK=1, BUSY=0, go to IDLE.
  - HANG: no DTACK; waits for nAS=1 and then goes to IDLE.
- Latency: nDTACK is low after edge W+1 counting the capture edge as 0. For W=0, nDTACK is low one clock after capture.
- Zone inputs are ignored after the capture edge. Wait inputs are sampled only at the capture edge.
- nAS rising in WAIT, PREADY or HANG aborts the cycle: next edge returns to IDLE, nDTACK stays 1, BUSY=0.
- Back-to-back cycles: nAS rising and falling with only a single sampled-high edge in between still gives one IDLE edge, because IDLE captures on the following edge.
- RW, nLDS and nUDS do not affect timing; they are passed to nothing and exist for ZONE_ID debug qualification only.

Optional Feature:
- Macro: C1_BERR_TIMEOUT_EN.
- With it: an 8-bit counter runs from the capture edge while state is WAIT, PREADY or HANG.
  - Reaching TIMEOUT_CYCLES sets nBERR=0 and goes to state BERR.
  - nBERR is held low until the edge where nAS=1, then the block returns to IDLE.
  - A cycle that reaches ACK never raises BERR.
- Without it: nBERR is tied to 1 and PREADY/HANG wait indefinitely.

Decomposition:
- Package c1_pkg holds:
  - ZONE_ID constants ZN_ROM..ZN_NONE (3-bit).
  - State enum IDLE, WAIT, PREADY, ACK, HANG, BERR.
  - The PWAIT decode function.
- One sub-module, c1_zone_encode: the combinational priority encoder from the zone selects to a 3-bit ID plus a valid flag.

Test Plan:
- WRAM read, nWRAM_ZONE=0, nAS low at edge 0 → nDTACK low after edge 1; nAS high → nDTACK high next edge, BUSY=0, ZONE_ID=1.
- ROM with nROMWAIT=0 → nDTACK low after edge 2. Same cycle with nROMWAIT=1 → low after edge 1.
- PORT with nPWAIT=00 and PDTACK held 0 for 5 extra clocks → nDTACK low 1 clock after PDTACK rises. PWAIT=11 with PDTACK=1 → low after edge 1.
- Unmapped address, all zone selects high:
  - Default build: nDTACK stays 1 for 300 clocks.
  - With C1_BERR_TIMEOUT_EN: nBERR low after 255 clocks, released on nAS high.
- CARD zone with nAS raised at edge 1 (abort) → nDTACK never asserts; the next WRAM cycle acks normally.
- RESET pulse while in WAIT → nDTACK=1, BUSY=0, ZONE_ID=7 asynchronously; the next cycle is sequenced correctly.

Source files
------------

// File: rtl/c1_pkg.sv
// Shared definitions for the C1 bus sequencer: zone identifiers, FSM state
// encoding and the cartridge port wait-code decode.
package c1_pkg;

    // Zone identifiers reported on ZONE_ID (lower value = higher priority)
    localparam logic [2:0] ZN_ROM  = 3'd0;
    localparam logic [2:0] ZN_WRAM = 3'd1;
    localparam logic [2:0] ZN_PORT = 3'd2;
    localparam logic [2:0] ZN_IO   = 3'd3;
    localparam logic [2:0] ZN_CARD = 3'd4;
    localparam logic [2:0] ZN_SROM = 3'd5;
    localparam logic [2:0] ZN_SRAM = 3'd6;
    localparam logic [2:0] ZN_NONE = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PREADY,
        ACK,
        HANG,
        BERR
    } state_t;

    // Port wait code: active-low pins, so the wait count is the inverted pair
    // (11 -> 0, 10 -> 1, 01 -> 2, 00 -> 3).
    function automatic logic [1:0] pwait_decode(input logic npwait1, input logic npwait0);
        return ~{npwait1, npwait0};
    endfunction

endpackage

// File: rtl/c1_zone_encode.sv
// Combinational priority encoder from the seven active-low zone selects to a
// 3-bit zone ID. Bit i of zone_n selects zone i; the lowest index wins.
module c1_zone_encode
    import c1_pkg::*;
(
    input  logic [6:0] zone_n,
    output logic [2:0] zone_id,
    output logic       zone_valid
);

    // Scan from lowest to highest priority so the highest-priority select wins
    always_comb begin
        zone_id    = ZN_NONE;
        zone_valid = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!zone_n[i]) begin
                zone_id    = 3'(i);
                zone_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/c1_bus_sequencer.sv
// C1 bus sequencer: captures the active zone when nAS falls, counts the
// per-zone wait states (including cartridge-driven waits) and drives nDTACK.
// Optional bus-error timeout is compiled in with C1_BERR_TIMEOUT_EN.
module c1_bus_sequencer
    import c1_pkg::*;
#(
    parameter int WAIT_CARD      = 2,
    parameter int WAIT_PAL       = 1,
    parameter int WAIT_SROM      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK_68KCLK,
    input  logic       RESET,
    input  logic       nAS,
    input  logic       RW,
    input  logic       nLDS,
    input  logic       nUDS,
    input  logic       nROM_ZONE,
    input  logic       nWRAM_ZONE,
    input  logic       nPORT_ZONE,
    input  logic       nIO_ZONE,
    input  logic       nCARD_ZONE,
    input  logic       nSROM_ZONE,
    input  logic       nSRAM_ZONE,
    input  logic       nPAL_ZONE,
    input  logic       nROMWAIT,
    input  logic       nPWAIT1,
    input  logic       nPWAIT0,
    input  logic       PDTACK,
    output logic       nDTACK,
    output logic       nBERR,
    output logic       BUSY,
    output logic [2:0] ZONE_ID
);

    logic [2:0] enc_id;
    logic       enc_valid;

    logic [2:0] cap_id;
    logic       cap_valid;
    logic       cap_port;
    logic [7:0] cap_wait;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       port_reg;
    logic       nberr_reg;
    logic       timeout_hit;

    // Strobes only qualify ZONE_ID for debug and never affect sequencing
    logic unused_strobes;
    assign unused_strobes = &{1'b0, RW, nLDS, nUDS};

    c1_zone_encode u_zone_encode (
        .zone_n     ({nSRAM_ZONE, nSROM_ZONE, nCARD_ZONE, nIO_ZONE,
                      nPORT_ZONE, nWRAM_ZONE, nROM_ZONE}),
        .zone_id    (enc_id),
        .zone_valid (enc_valid)
    );

    // Zone and wait count as they would be latched on a capture edge.
    // The palette select overrides the encoder; it reports as the SRAM ID
    // only when SRAM itself is not selected.
    always_comb begin
        cap_id    = enc_id;
        cap_valid = enc_valid;
        cap_port  = enc_valid && (enc_id == ZN_PORT);
        cap_wait  = 8'd0;
        if (!nPAL_ZONE) begin
            cap_valid = 1'b1;
            cap_port  = 1'b0;
            cap_wait  = 8'(WAIT_PAL);
            if (nSRAM_ZONE) begin
                cap_id = ZN_SRAM;
            end
        end else if (enc_valid) begin
            case (enc_id)
                ZN_ROM:  cap_wait = nROMWAIT ? 8'd0 : 8'd1;
                ZN_PORT: cap_wait = {6'd0, pwait_decode(nPWAIT1, nPWAIT0)};
                ZN_CARD: cap_wait = 8'(WAIT_CARD);
                ZN_SROM: cap_wait = 8'(WAIT_SROM);
                default: cap_wait = 8'd0;
            endcase
        end
    end

`ifdef C1_BERR_TIMEOUT_EN
    logic [7:0] tcnt_reg;

    assign timeout_hit = (tcnt_reg == 8'(TIMEOUT_CYCLES - 1));

    // Timeout counter: cleared at capture, runs while the cycle is stalled
    always_ff @(posedge CLK_68KCLK or posedge RESET) begin
        if (RESET) begin
            tcnt_reg <= 8'd0;
        end else if (state_reg == IDLE) begin
            tcnt_reg <= 8'd0;
        end else if (state_reg == WAIT || state_reg == PREADY || state_reg == HANG) begin
            tcnt_reg <= tcnt_reg + 8'd1;
        end
    end
`else
    // Without the timeout nothing ever fires, so nBERR stays at its reset value
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    assign nBERR = nberr_reg;

    // Bus-cycle FSM with registered nDTACK / nBERR / BUSY / ZONE_ID
    always_ff @(posedge CLK_68KCLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            port_reg  <= 1'b0;
            nDTACK    <= 1'b1;
            nberr_reg <= 1'b1;
            BUSY      <= 1'b0;
            ZONE_ID   <= ZN_NONE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!nAS) begin
                        ZONE_ID  <= cap_id;
                        BUSY     <= 1'b1;
                        cnt_reg  <= cap_wait;
                        port_reg <= cap_port;
                        if (!cap_valid) begin
                            state_reg <= HANG;
                        end else if (cap_wait == 8'd0) begin
                            state_reg <= ACK;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (nAS) begin
                        state_reg <= IDLE;
                        BUSY      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                        if (cnt_reg == 8'd1) begin
                            state_reg <= port_reg ? PREADY : ACK;
                        end else if (timeout_hit) begin
                            state_reg <= BERR;
                            nberr_reg <= 1'b0;
                        end
                    end
                end
                PREADY: begin
                    if (nAS) begin
                        state_reg <= IDLE;
                        BUSY      <= 1'b0;
                    end else if (PDTACK) begin
                        state_reg <= ACK;
                    end else if (timeout_hit) begin
                        state_reg <= BERR;
                        nberr_reg <= 1'b0;
                    end
                end
                ACK: begin
                    if (nAS) begin
                        state_reg <= IDLE;
                        nDTACK    <= 1'b1;
                        BUSY      <= 1'b0;
                    end else begin
                        nDTACK <= 1'b0;
                    end
                end
                HANG: begin
                    if (nAS) begin
                        state_reg <= IDLE;
                        BUSY      <= 1'b0;
                    end else if (timeout_hit) begin
                        state_reg <= BERR;
                        nberr_reg <= 1'b0;
                    end
                end
                BERR: begin
                    if (nAS) begin
                        state_reg <= IDLE;
                        nberr_reg <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    nDTACK    <= 1'b1;
                    nberr_reg <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_bus_sequencer.sv
// Directed testbench for c1_bus_sequencer with a scoreboard of expected
// zone / DTACK latency per bus cycle. Build with C1_BERR_TIMEOUT_EN to
// exercise the bus-error timeout path.
module tb_c1_bus_sequencer;
    import c1_pkg::*;

    logic       CLK_68KCLK = 1'b0;
    logic       RESET;
    logic       nAS, RW, nLDS, nUDS;
    logic [7:0] zsel;   // {PAL,SRAM,SROM,CARD,IO,PORT,WRAM,ROM}, active low
    logic       nROMWAIT, nPWAIT1, nPWAIT0, PDTACK;
    logic       nDTACK, nBERR, BUSY;
    logic [2:0] ZONE_ID;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [2:0] zone;
        int         lat;
    } exp_t;
    exp_t sb[$];

    localparam logic [7:0] ZS_NONE = 8'hFF;
    localparam logic [7:0] ZS_ROM  = 8'hFE;
    localparam logic [7:0] ZS_WRAM = 8'hFD;
    localparam logic [7:0] ZS_PORT = 8'hFB;
    localparam logic [7:0] ZS_IO   = 8'hF7;
    localparam logic [7:0] ZS_CARD = 8'hEF;
    localparam logic [7:0] ZS_SROM = 8'hDF;
    localparam logic [7:0] ZS_SRAM = 8'hBF;
    localparam logic [7:0] ZS_PAL  = 8'h7F;

    always #5 CLK_68KCLK = ~CLK_68KCLK;

    c1_bus_sequencer dut (
        .CLK_68KCLK (CLK_68KCLK),
        .RESET      (RESET),
        .nAS        (nAS),
        .RW         (RW),
        .nLDS       (nLDS),
        .nUDS       (nUDS),
        .nROM_ZONE  (zsel[0]),
        .nWRAM_ZONE (zsel[1]),
        .nPORT_ZONE (zsel[2]),
        .nIO_ZONE   (zsel[3]),
        .nCARD_ZONE (zsel[4]),
        .nSROM_ZONE (zsel[5]),
        .nSRAM_ZONE (zsel[6]),
        .nPAL_ZONE  (zsel[7]),
        .nROMWAIT   (nROMWAIT),
        .nPWAIT1    (nPWAIT1),
        .nPWAIT0    (nPWAIT0),
        .PDTACK     (PDTACK),
        .nDTACK     (nDTACK),
        .nBERR      (nBERR),
        .BUSY       (BUSY),
        .ZONE_ID    (ZONE_ID)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_68KCLK);
        #1;
    endtask

    // Edge index (capture = 0) after which nDTACK is low. A port cycle with
    // waits passes through PREADY at edge w, then needs a sampled PDTACK=1.
    // PDTACK is driven high just after edge pd (pd < 0: high from the start).
    function automatic int lat_model(input int w, input bit is_port, input int pd);
        int e;
        if (!is_port || w == 0) return w + 1;
        e = (pd + 1 > w + 1) ? pd + 1 : w + 1;
        return e + 1;
    endfunction

    task automatic run_cycle(input string tag, input logic [7:0] zs, input logic romwait,
                             input logic [1:0] pw, input int pd, input logic [2:0] zone,
                             input int w, input bit is_port);
        exp_t e;
        int   lat_obs;
        e.tag  = tag;
        e.zone = zone;
        e.lat  = lat_model(w, is_port, pd);
        sb.push_back(e);

        zsel     = zs;
        nROMWAIT = romwait;
        {nPWAIT1, nPWAIT0} = pw;
        PDTACK   = (pd < 0);
        RW       = 1'($urandom);
        nLDS     = 1'($urandom);
        nUDS     = 1'($urandom);
        nAS      = 1'b0;

        lat_obs = -1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            if (k == 0) begin
                check({tag, ".busy_capture"}, 32'(BUSY), 32'd1);
                // Zone and wait inputs must be ignored after capture
                zsel     = ZS_NONE;
                nROMWAIT = ~romwait;
                {nPWAIT1, nPWAIT0} = ~pw;
            end
            if (nDTACK === 1'b0) begin
                lat_obs = k;
                break;
            end
            if (k == pd) PDTACK = 1'b1;
        end

        e = sb.pop_front();
        check({e.tag, ".latency"}, 32'(lat_obs), 32'(e.lat));
        check({e.tag, ".zone"}, 32'(ZONE_ID), 32'(e.zone));

        // DTACK holds while nAS stays low
        tick();
        check({e.tag, ".dtack_hold"}, 32'(nDTACK), 32'd0);

        nAS = 1'b1;
        tick();
        check({e.tag, ".dtack_release"}, 32'(nDTACK), 32'd1);
        check({e.tag, ".busy_release"}, 32'(BUSY), 32'd0);
        check({e.tag, ".zone_kept"}, 32'(ZONE_ID), 32'(e.zone));
        PDTACK = 1'b0;
        $display("txn %s zone=%0d latency=%0d expected_latency=%0d", e.tag, ZONE_ID, lat_obs, e.lat);
    endtask

    initial begin
        int low_cnt;
        int berr_edge;
        exp_t e;

        RESET = 1'b1;
        nAS = 1'b1; RW = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
        zsel = ZS_NONE; nROMWAIT = 1'b1; nPWAIT1 = 1'b1; nPWAIT0 = 1'b1; PDTACK = 1'b0;
        #1;
        check("reset.ndtack", 32'(nDTACK), 32'd1);
        check("reset.nberr", 32'(nBERR), 32'd1);
        check("reset.busy", 32'(BUSY), 32'd0);
        check("reset.zone", 32'(ZONE_ID), 32'(ZN_NONE));
        tick();
        tick();
        RESET = 1'b0;
        tick();
        $display("txn reset zone=%0d busy=%0d", ZONE_ID, BUSY);

        // Main function: per-zone waits, cartridge waits, priority, palette
        run_cycle("wram",        ZS_WRAM, 1'b1, 2'b11, -1, ZN_WRAM, 0, 1'b0);
        run_cycle("rom_wait",    ZS_ROM,  1'b0, 2'b11, -1, ZN_ROM,  1, 1'b0);
        run_cycle("rom_nowait",  ZS_ROM,  1'b1, 2'b11, -1, ZN_ROM,  0, 1'b0);
        run_cycle("port_pw00",   ZS_PORT, 1'b1, 2'b00,  8, ZN_PORT, 3, 1'b1);
        run_cycle("port_pw11",   ZS_PORT, 1'b1, 2'b11, -1, ZN_PORT, 0, 1'b1);
        run_cycle("port_pw10",   ZS_PORT, 1'b1, 2'b10, -1, ZN_PORT, 1, 1'b1);
        run_cycle("port_pw01",   ZS_PORT, 1'b1, 2'b01,  1, ZN_PORT, 2, 1'b1);
        run_cycle("card",        ZS_CARD, 1'b1, 2'b11, -1, ZN_CARD, 2, 1'b0);
        run_cycle("srom",        ZS_SROM, 1'b1, 2'b11, -1, ZN_SROM, 0, 1'b0);
        run_cycle("sram",        ZS_SRAM, 1'b1, 2'b11, -1, ZN_SRAM, 0, 1'b0);
        run_cycle("io",          ZS_IO,   1'b1, 2'b11, -1, ZN_IO,   0, 1'b0);
        run_cycle("pal",         ZS_PAL,  1'b1, 2'b11, -1, ZN_SRAM, 1, 1'b0);
        run_cycle("prio_rom",    ZS_ROM & ZS_WRAM & ZS_IO, 1'b1, 2'b11, -1, ZN_ROM, 0, 1'b0);
        run_cycle("prio_port",   ZS_PORT & ZS_CARD, 1'b1, 2'b11, -1, ZN_PORT, 0, 1'b1);

        // Unmapped address: never acknowledged; optional timeout raises nBERR
        e.tag = "unmapped"; e.zone = ZN_NONE; e.lat = -1;
        sb.push_back(e);
        zsel = ZS_NONE;
        nAS  = 1'b0;
        low_cnt = 0;
        berr_edge = -1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (nDTACK !== 1'b1) low_cnt++;
            if (nBERR === 1'b0 && berr_edge < 0) berr_edge = k;
        end
        e = sb.pop_front();
        check({e.tag, ".dtack_lows"}, 32'(low_cnt), 32'd0);
        check({e.tag, ".zone"}, 32'(ZONE_ID), 32'(e.zone));
        check({e.tag, ".busy"}, 32'(BUSY), 32'd1);
`ifdef C1_BERR_TIMEOUT_EN
        check({e.tag, ".berr_edge"}, 32'(berr_edge), 32'd255);
`else
        check({e.tag, ".berr_edge"}, 32'(berr_edge), 32'(-1));
`endif
        nAS = 1'b1;
        tick();
        check({e.tag, ".busy_release"}, 32'(BUSY), 32'd0);
        check({e.tag, ".nberr_release"}, 32'(nBERR), 32'd1);
        $display("txn unmapped dtack_lows=%0d berr_edge=%0d", low_cnt, berr_edge);

        // Abort: CARD cycle with nAS raised before the waits expire
        zsel = ZS_CARD;
        nAS  = 1'b0;
        tick();
        check("abort.zone", 32'(ZONE_ID), 32'(ZN_CARD));
        nAS  = 1'b1;
        zsel = ZS_NONE;
        low_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (nDTACK !== 1'b1) low_cnt++;
            if (k == 1) check("abort.busy", 32'(BUSY), 32'd0);
        end
        check("abort.dtack_lows", 32'(low_cnt), 32'd0);
        $display("txn abort dtack_lows=%0d", low_cnt);
        run_cycle("wram_after_abort", ZS_WRAM, 1'b1, 2'b11, -1, ZN_WRAM, 0, 1'b0);

        // Asynchronous reset in the middle of a WAIT state
        zsel = ZS_CARD;
        nAS  = 1'b0;
        tick();
        tick();
        check("midreset.busy_before", 32'(BUSY), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("midreset.ndtack", 32'(nDTACK), 32'd1);
        check("midreset.busy", 32'(BUSY), 32'd0);
        check("midreset.zone", 32'(ZONE_ID), 32'(ZN_NONE));
        nAS  = 1'b1;
        zsel = ZS_NONE;
        tick();
        RESET = 1'b0;
        tick();
        check("midreset.ndtack_after", 32'(nDTACK), 32'd1);
        $display("txn midreset zone=%0d busy=%0d", ZONE_ID, BUSY);
        run_cycle("wram_after_reset", ZS_WRAM, 1'b1, 2'b11, -1, ZN_WRAM, 0, 1'b0);
        run_cycle("card_after_reset", ZS_CARD, 1'b1, 2'b11, -1, ZN_CARD, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
